ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered operands data1/data2 and the M-extension funct3.
- Returns a 32-bit result that EX muxes onto the ALU result path.
- Drives busy into the pipeline busywait OR-tree, so the ID/EX register and all upstream stages hold while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8; iteration counter is $clog2(XLEN) bits

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
start  input  1  EX holds an M-extension instruction; sampled only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
data1  input  XLEN  rs1 operand (dividend / multiplicand)
data2  input  XLEN  rs2 operand (divisor / multiplier)
flush  input  1  abort current operation (branch/jump taken)
busy  output  1  stall request to pipeline busywait
done  output  1  one-cycle pulse; result valid this cycle
result  output  XLEN  registered result, held until the next accepted start or reset

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; result=0; done=0; all internal accumulators, counter and sign flags are cleared.
  - Reset overrides every other input, including during CALC or FIX.
- busy is combinational: (state==IDLE & start & !flush) | state==CALC | state==FIX. It is deasserted in DONE so the pipeline advances on the done cycle.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 and flush=0 (cycle n):
  - Latch funct3, operand magnitudes and sign flags; counter=XLEN-1.
  - Signed ops: MULH (both operands), MULHSU (rs1 only), DIV/REM (both). Other ops treat operands as unsigned.
  - Special cases go IDLE->DONE, so done and result appear at n+1:
    - divisor==0: DIV/DIVU -> all ones; REM/REMU -> data1.
    - DIV/REM with data1==0x80000000 and data2==all ones: DIV -> 0x80000000; REM -> 0.
  - Otherwise go to CALC at n+1.
- CALC, XLEN cycles (n+1..n+XLEN):
  - Multiply: radix-2 shift-add on 2*XLEN-bit product.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements each cycle; at counter==0 go to FIX.
- FIX, cycle n+XLEN+1: apply signs.
  - Product is negated if sign1^sign2 (MULHSU uses sign1 only).
  - Quotient is negated if sign1^sign2; remainder is negated if sign1.
  - Select the low half (MUL) or high half (MULH/MULHSU/MULHU), quotient, or remainder, and register it into result.
- DONE, cycle n+XLEN+2: done=1, then IDLE next cycle. A new start is not accepted in DONE, only in IDLE.
- start while not in IDLE: ignored.
- funct3 and data changes after acceptance: no effect on the operation in flight.
- flush=1 in any non-IDLE state: go to IDLE next cycle, done is never asserted, and result keeps its previous value.
- flush=1 together with start in IDLE: start is not accepted and busy=0.
- Nominal latency: start to done = XLEN+2 cycles (34 for XLEN=32).

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - All four multiply ops use a single-cycle combinational (XLEN+1)x(XLEN+1) signed multiplier.
  - Path is IDLE->DONE; result and done appear at n+1; busy is high only in cycle n.
  - Divides are unchanged.
- Undefined: multiplies take the iterative path, with done at n+XLEN+2.

Test Plan:
- MUL data1=7, data2=0xFFFFFFFD, start at cycle n -> busy high n..n+33, done at n+34, result=0xFFFFFFEB (n+1 with MULDIV_FAST_MUL_EN).
- MULH 0x80000000*0x80000000 -> result=0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with done at n+34.
- DIVU 5/0 -> 0xFFFFFFFF at n+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at n+1; REM same operands -> 0.
- Start a DIV, pulse start with a different funct3 at CALC cycle 5 -> ignored, original DIV result returned at n+34.
- Drive reset=0 at CALC cycle 10 -> next edge busy=0, done=0, result=0, state IDLE. Separately, flush at CALC cycle 10 -> IDLE next cycle, no done pulse, prior result retained.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage handshake between the pipeline (master) and the mul/div unit (slave).
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic            flush;
    logic            busy;
    logic            done;
    logic [2:0]      funct3;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] result;
    modport master(output start, funct3, data1, data2, flush, input busy, done, result);
    modport slave(input start, funct3, data1, data2, flush, output busy, done, result);
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide (shift-add / restoring), XLEN+2 cycle latency.
// Define MULDIV_FAST_MUL_EN to compute all multiplies in one cycle with a combinational multiplier.
module ex_muldiv_unit #(parameter int XLEN = 32) (
    input logic clk,
    input logic reset,
    ex_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
    logic [1:0]        state;
    logic [2:0]        op;
    logic [CW-1:0]     cnt;
    logic              sign1, sign2;
    logic [XLEN-1:0]   opnd, hi, lo, result;
    logic              is_div, s1_op, s2_op, sgn1_in, sgn2_in, div_zero, div_ovf;
    logic [XLEN-1:0]   abs1, abs2, special_res, quo_fix, rem_fix, fix_res, fast_res;
    logic [XLEN:0]     add_sum, shifted, diff;
    logic [2*XLEN-1:0] prod_fix;
    logic              fast;
    assign is_div  = bus.funct3[2];
    assign s1_op   = is_div ? !bus.funct3[0] : (bus.funct3[1] ^ bus.funct3[0]);
    assign s2_op   = is_div ? !bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    assign sgn1_in = s1_op & bus.data1[XLEN-1];
    assign sgn2_in = s2_op & bus.data2[XLEN-1];
    assign abs1    = sgn1_in ? -bus.data1 : bus.data1;
    assign abs2    = sgn2_in ? -bus.data2 : bus.data2;
    assign div_zero = is_div && bus.data2 == '0;
    assign div_ovf  = is_div && !bus.funct3[0] && bus.data1 == {1'b1, {(XLEN-1){1'b0}}} && bus.data2 == '1;
    // Overflow DIV returns the dividend itself (the most negative value)
    assign special_res = div_zero ? (bus.funct3[1] ? bus.data1 : '1) : (bus.funct3[1] ? '0 : bus.data1);
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fp;
    assign fp       = {{XLEN{sgn1_in}}, bus.data1} * {{XLEN{sgn2_in}}, bus.data2};
    assign fast     = !is_div;
    assign fast_res = bus.funct3[1:0] == 2'b00 ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif
    // {hi,lo} is the product register for multiply, {remainder,quotient} for divide
    assign add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign shifted  = {hi, lo[XLEN-1]};
    assign diff     = shifted - {1'b0, opnd};
    assign prod_fix = (sign1 ^ sign2) ? -{hi, lo} : {hi, lo};
    assign quo_fix  = (sign1 ^ sign2) ? -lo : lo;
    assign rem_fix  = sign1 ? -hi : hi;
    assign fix_res  = op[2] ? (op[1] ? rem_fix : quo_fix)
                            : (op[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
    assign bus.busy   = (state == IDLE && bus.start && !bus.flush) || state == CALC || state == FIX;
    assign bus.done   = state == DONE && !bus.flush;
    assign bus.result = result;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            op     <= '0;
            cnt    <= '0;
            sign1  <= 1'b0;
            sign2  <= 1'b0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
        end else if (bus.flush && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start && !bus.flush) begin
                    op    <= bus.funct3;
                    sign1 <= sgn1_in;
                    sign2 <= sgn2_in;
                    cnt   <= CW'(XLEN-1);
                    opnd  <= is_div ? abs2 : abs1;
                    hi    <= '0;
                    lo    <= is_div ? abs1 : abs2;
                    if (div_zero || div_ovf) begin
                        result <= special_res;
                        state  <= DONE;
                    end else if (fast) begin
                        result <= fast_res;
                        state  <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (op[2]) begin
                        hi <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], !diff[XLEN]};
                    end else begin
                        hi <= add_sum[XLEN:1];
                        lo <= {add_sum[0], lo[XLEN-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and randomized checks of ex_muldiv_unit against a 64-bit arithmetic model.
module tb_ex_muldiv_unit;
    localparam logic [31:0] MIN = 32'h8000_0000;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    ex_muldiv_unit_if #(.XLEN(32)) bus();
    ex_muldiv_unit #(.XLEN(32)) dut(.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 34;
    endfunction

    // Called at a falling edge; returns at the falling edge one cycle after done.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int glitch);
        int k;
        bus.start = 1'b1;
        bus.funct3 = f3;
        bus.data1 = a;
        bus.data2 = b;
        #1 check("busy_accept", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.data1 = $urandom;
        bus.data2 = $urandom;
        k = 1;
        while (!bus.done && k < 100) begin
            check("busy_run", 32'(bus.busy), 32'd1);
            bus.start = (k == glitch);
            if (k == glitch) bus.funct3 = f3 ^ 3'b001;
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        check("latency", 32'(k), 32'(exp_lat(f3, a, b)));
        check("result", bus.result, exp);
        check("busy_done", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
        check("result_hold", bus.result, exp);
    endtask

    typedef struct { logic [2:0] f3; logic [31:0] a, b, exp; } vec_t;
    vec_t dir[$] = '{
        '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd1, MIN, MIN, 32'h4000_0000},
        '{3'd3, MIN, MIN, 32'h4000_0000},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
        '{3'd5, 32'd100, 32'd7, 32'd14},
        '{3'd7, 32'd100, 32'd7, 32'd2},
        '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF},
        '{3'd6, 32'd5, 32'd0, 32'd5},
        '{3'd4, MIN, 32'hFFFF_FFFF, MIN},
        '{3'd6, MIN, 32'hFFFF_FFFF, 32'd0}
    };

    initial begin
        int dones;
        logic [2:0] f3;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.funct3 = '0;
        bus.data1 = '0;
        bus.data2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        foreach (dir[i]) do_op(dir[i].f3, dir[i].a, dir[i].b, dir[i].exp, 0);
        do_op(3'd4, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FFAB, 5);
        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 0;
                1: begin a = MIN; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 300));
                default: ;
            endcase
            do_op(f3, a, b, ref_model(f3, a, b), 0);
        end
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 0);
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.data1 = 32'd1000; bus.data2 = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("rst_mid_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        check("rst_mid_result", bus.result, 32'd0);
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 0);
        bus.start = 1'b1; bus.funct3 = 3'd6; bus.data1 = 32'd999; bus.data2 = 32'd10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        dones = 0;
        repeat (40) begin
            dones += int'(bus.done);
            @(negedge clk);
        end
        check("flush_no_done", 32'(dones), 32'd0);
        check("flush_result", bus.result, 32'd14);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd5; bus.data1 = 32'd50; bus.data2 = 32'd5;
        #1 check("flush_start_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_idle", 32'(bus.busy), 32'd0);
        dones = 0;
        repeat (40) begin
            dones += int'(bus.done);
            @(negedge clk);
        end
        check("flush_start_no_done", 32'(dones), 32'd0);
        check("flush_start_result", bus.result, 32'd14);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
